// File: rtl/serial_rx_framed_if.sv
// Bus bundle between the framed serial receiver and its consumer.
// master = receiver side, slave = consumer/line-driver side.
interface serial_rx_framed_if #(
   parameter int DATA_BITS = 8
);
   logic                 data_in;
   logic [DATA_BITS-1:0] data_out;
   logic                 data_valid;
   logic                 data_ready;
   logic                 character_received;
   logic                 parity_err;
   logic                 framing_err;
   logic                 overrun;
   logic                 overrun_clr;
   logic                 busy;

   modport master (
      input  data_in, data_ready, overrun_clr,
      output data_out, data_valid, character_received, parity_err,
             framing_err, overrun, busy
   );

   modport slave (
      output data_in, data_ready, overrun_clr,
      input  data_out, data_valid, character_received, parity_err,
             framing_err, overrun, busy
   );
endinterface

// File: rtl/serial_rx_framed.sv
// Oversampling async serial receiver with parity/framing checks and a
// valid/ready holding register with sticky overrun.
//   state    | meaning
//   S_IDLE   | line idle, waiting for rx_s low
//   S_START  | half-bit wait, confirm start bit (else glitch -> idle)
//   S_DATA   | sampling payload bits at bit centres
//   S_PARITY | sampling parity bit
//   S_STOP   | sampling stop bit, frame completes on the sample
module serial_rx_framed #(
   parameter int DATA_BITS  = 8,
   parameter int CLK_DIV    = 434,
   parameter int OVERSAMPLE = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int MSB_FIRST  = 0
) (
   input logic              clk,
   input logic              rst,
   serial_rx_framed_if.master bus
);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int SW = $clog2(OVERSAMPLE);
   localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [SW-1:0] SMP_HALF = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] SMP_FULL = SW'(OVERSAMPLE - 1);
   localparam logic [IW-1:0] BIT_LAST = IW'(DATA_BITS - 1);
   localparam logic          ODD      = (PARITY_ODD != 0);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
   state_t r_state, w_state_nxt;

   logic                 r_sync1, r_sync2, w_rx_s;
   logic [DW-1:0]        r_div;
   logic                 w_tick;
   logic [SW-1:0]        r_smp;
   logic                 w_at_pt;
   logic [IW-1:0]        r_bit, w_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par_bad;
   logic                 w_arm, w_shift, w_par_smp, w_done, w_accept;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_valid, r_char, r_perr, r_ferr, r_ovr;

   assign w_rx_s   = r_sync2;
   assign w_tick   = (r_div == DIV_LAST);
   assign w_at_pt  = w_tick && (r_smp == ((r_state == S_START) ? SMP_HALF : SMP_FULL));
   assign w_idx    = (MSB_FIRST != 0) ? (BIT_LAST - r_bit) : r_bit;
   assign w_accept = r_valid & bus.data_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_arm       = 1'b0;
      w_shift     = 1'b0;
      w_par_smp   = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_rx_s) begin
               w_state_nxt = S_START;
               w_arm       = 1'b1;
            end
         end
         S_START: begin
            if (w_at_pt) w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (w_at_pt) begin
               w_shift = 1'b1;
               if (r_bit == BIT_LAST) w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            if (w_at_pt) begin
               w_par_smp   = 1'b1;
               w_state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (w_at_pt) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Synchroniser presets high so reset release never looks like a start bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_div     <= '0;
         r_smp     <= '0;
         r_bit     <= '0;
         r_shift   <= '0;
         r_par_bad <= 1'b0;
      end else begin
         r_sync1 <= bus.data_in;
         r_sync2 <= r_sync1;
         if (w_arm || w_tick) r_div <= '0;
         else                 r_div <= r_div + 1'b1;
         if (w_arm)                             r_smp <= '0;
         else if (w_tick && r_state != S_IDLE) r_smp <= w_at_pt ? '0 : r_smp + 1'b1;
         if (w_arm) begin
            r_bit     <= '0;
            r_par_bad <= 1'b0;
         end else if (w_shift) begin
            r_shift[w_idx] <= w_rx_s;
            r_bit          <= r_bit + IW'(1);
         end
         if (w_par_smp) r_par_bad <= ((^r_shift) ^ w_rx_s) != ODD;
      end
   end

   // A completed frame is dropped (and flagged) only if the held one is not leaving.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_char  <= 1'b0;
         r_perr  <= 1'b0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_char <= w_done;
         if (w_done && (!r_valid || w_accept)) begin
            r_data  <= r_shift;
            r_perr  <= r_par_bad;
            r_ferr  <= ~w_rx_s;
            r_valid <= 1'b1;
         end else if (w_accept) begin
            r_valid <= 1'b0;
         end
         if (bus.overrun_clr)                          r_ovr <= 1'b0;
         else if (w_done && r_valid && !bus.data_ready) r_ovr <= 1'b1;
      end
   end

   assign bus.data_out           = r_data;
   assign bus.data_valid         = r_valid;
   assign bus.character_received = r_char;
   assign bus.parity_err         = r_perr;
   assign bus.framing_err        = r_ferr;
   assign bus.overrun            = r_ovr;
   assign bus.busy               = (r_state != S_IDLE);
endmodule

// File: tb/tb_serial_rx_framed.sv
// Scoreboard bench for serial_rx_framed: three instances (8N1, 8E1, 12-bit MSB-first).
module tb_serial_rx_framed;
   localparam int CLK_DIV = 4;
   localparam int OS      = 8;
   localparam int BIT     = CLK_DIV * OS;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   serial_rx_framed_if #(.DATA_BITS(8))  a_if ();
   serial_rx_framed_if #(.DATA_BITS(8))  p_if ();
   serial_rx_framed_if #(.DATA_BITS(12)) w_if ();

   serial_rx_framed #(.DATA_BITS(8), .CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .PARITY_EN(0),
                      .PARITY_ODD(0), .MSB_FIRST(0)) u_a (.clk(clk), .rst(rst_n), .bus(a_if));
   serial_rx_framed #(.DATA_BITS(8), .CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .PARITY_EN(1),
                      .PARITY_ODD(0), .MSB_FIRST(0)) u_p (.clk(clk), .rst(rst_n), .bus(p_if));
   serial_rx_framed #(.DATA_BITS(12), .CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .PARITY_EN(0),
                      .PARITY_ODD(0), .MSB_FIRST(1)) u_w (.clk(clk), .rst(rst_n), .bus(w_if));

   typedef struct packed {
      logic [15:0] data;
      logic        perr;
      logic        ferr;
   } rec_t;

   rec_t exp_a[$], obs_a[$], exp_p[$], obs_p[$], exp_w[$], obs_w[$];
   int checks   = 0;
   int failures = 0;

   always @(negedge clk) begin
      if (a_if.character_received === 1'b1)
         obs_a.push_back(rec_t'{16'(a_if.data_out), a_if.parity_err, a_if.framing_err});
      if (p_if.character_received === 1'b1)
         obs_p.push_back(rec_t'{16'(p_if.data_out), p_if.parity_err, p_if.framing_err});
      if (w_if.character_received === 1'b1)
         obs_w.push_back(rec_t'{16'(w_if.data_out), w_if.parity_err, w_if.framing_err});
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "bench time limit exceeded");
   end

   task automatic set_line(input int which, input logic v);
      case (which)
         0:       a_if.data_in = v;
         1:       p_if.data_in = v;
         default: w_if.data_in = v;
      endcase
   endtask

   task automatic send_frame(input int which, input logic [15:0] d, input int nbits,
                             input bit msb, input bit has_par, input bit par, input bit stop_ok);
      set_line(which, 1'b0);
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         set_line(which, msb ? d[nbits-1-i] : d[i]);
         repeat (BIT) @(negedge clk);
      end
      if (has_par) begin
         set_line(which, par);
         repeat (BIT) @(negedge clk);
      end
      if (stop_ok) begin
         set_line(which, 1'b1);
         repeat (BIT) @(negedge clk);
      end else begin
         set_line(which, 1'b0);
         repeat (BIT/2 + 6) @(negedge clk);
         set_line(which, 1'b1);
         repeat (BIT/2 - 6) @(negedge clk);
      end
      repeat (BIT) @(negedge clk);
   endtask

   task automatic wait_obs(input int which, output bit got);
      int sz;
      got = 1'b0;
      for (int i = 0; i < 400; i++) begin
         case (which)
            0:       sz = obs_a.size();
            1:       sz = obs_p.size();
            default: sz = obs_w.size();
         endcase
         if (sz > 0) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({a_if.data_out, a_if.data_valid, a_if.character_received, a_if.parity_err,
           a_if.framing_err, a_if.overrun, a_if.busy} !== '0) begin
         failures++;
         $display("FAIL reset_a got=%h/v%b/o%b/b%b exp=0", a_if.data_out, a_if.data_valid,
                  a_if.overrun, a_if.busy);
      end
      checks++;
      if ({p_if.data_out, p_if.data_valid, p_if.character_received, p_if.parity_err,
           p_if.framing_err, p_if.overrun, p_if.busy} !== '0) begin
         failures++;
         $display("FAIL reset_p got=%h/v%b/o%b/b%b exp=0", p_if.data_out, p_if.data_valid,
                  p_if.overrun, p_if.busy);
      end
      checks++;
      if ({w_if.data_out, w_if.data_valid, w_if.character_received, w_if.parity_err,
           w_if.framing_err, w_if.overrun, w_if.busy} !== '0) begin
         failures++;
         $display("FAIL reset_w got=%h/v%b/o%b/b%b exp=0", w_if.data_out, w_if.data_valid,
                  w_if.overrun, w_if.busy);
      end
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if ({a_if.busy, p_if.busy, w_if.busy} !== 3'b000 || obs_a.size() != 0) begin
         failures++;
         $display("FAIL idle_after_reset got=busy%b%b%b/n%0d exp=busy000/n0", a_if.busy,
                  p_if.busy, w_if.busy, obs_a.size());
      end
   endtask

   task automatic test_basic();
      logic [7:0] pat [2];
      rec_t o, e;
      bit   got;
      pat = '{8'hA5, 8'h3C};
      a_if.data_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         exp_a.push_back(rec_t'{16'(pat[i]), 1'b0, 1'b0});
         send_frame(0, 16'(pat[i]), 8, 1'b0, 1'b0, 1'b0, 1'b1);
         wait_obs(0, got);
         checks++;
         if (!got) begin
            failures++;
            exp_a.delete();
            $display("FAIL basic_pulse got=none exp=%h", pat[i]);
         end else begin
            o = obs_a.pop_front();
            e = exp_a.pop_front();
            checks++;
            if (o !== e) begin
               failures++;
               $display("FAIL basic_char got=%h/p%b/f%b exp=%h/p%b/f%b", o.data, o.perr, o.ferr,
                        e.data, e.perr, e.ferr);
            end
         end
         checks++;
         if (obs_a.size() != 0) begin
            failures++;
            $display("FAIL basic_single_pulse got=%0d exp=0", obs_a.size());
            obs_a.delete();
         end
         checks++;
         if (a_if.data_valid !== 1'b0 || a_if.data_out !== pat[i]) begin
            failures++;
            $display("FAIL basic_consumed got=v%b/%h exp=v0/%h", a_if.data_valid, a_if.data_out,
                     pat[i]);
         end
      end
   endtask

   task automatic test_parity();
      rec_t o, e;
      bit   got;
      p_if.data_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         exp_p.push_back(rec_t'{16'h0007, (i == 1), 1'b0});
         send_frame(1, 16'h0007, 8, 1'b0, 1'b1, (i == 0), 1'b1);
         wait_obs(1, got);
         checks++;
         if (!got) begin
            failures++;
            exp_p.delete();
            $display("FAIL parity_pulse got=none exp=07");
         end else begin
            o = obs_p.pop_front();
            e = exp_p.pop_front();
            checks++;
            if (o !== e) begin
               failures++;
               $display("FAIL parity_char got=%h/p%b/f%b exp=%h/p%b/f%b", o.data, o.perr, o.ferr,
                        e.data, e.perr, e.ferr);
            end
         end
      end
   endtask

   task automatic test_framing();
      rec_t o, e;
      bit   got;
      a_if.data_ready = 1'b0;
      exp_a.push_back(rec_t'{16'h0055, 1'b0, 1'b1});
      send_frame(0, 16'h0055, 8, 1'b0, 1'b0, 1'b0, 1'b0);
      wait_obs(0, got);
      checks++;
      if (!got) begin
         failures++;
         exp_a.delete();
         $display("FAIL framing_pulse got=none exp=55");
      end else begin
         o = obs_a.pop_front();
         e = exp_a.pop_front();
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL framing_char got=%h/p%b/f%b exp=%h/p%b/f%b", o.data, o.perr, o.ferr,
                     e.data, e.perr, e.ferr);
         end
      end
      checks++;
      if (a_if.data_valid !== 1'b1 || a_if.busy !== 1'b0 || obs_a.size() != 0) begin
         failures++;
         $display("FAIL framing_hold got=v%b/b%b/n%0d exp=v1/b0/n0", a_if.data_valid, a_if.busy,
                  obs_a.size());
      end
      a_if.data_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (a_if.data_valid !== 1'b0 || a_if.data_out !== 8'h55) begin
         failures++;
         $display("FAIL framing_consume got=v%b/%h exp=v0/55", a_if.data_valid, a_if.data_out);
      end
   endtask

   task automatic test_glitch();
      set_line(0, 1'b0);
      repeat (5) @(negedge clk);
      checks++;
      if (a_if.busy !== 1'b1) begin
         failures++;
         $display("FAIL glitch_armed got=b%b exp=b1", a_if.busy);
      end
      repeat (3) @(negedge clk);
      set_line(0, 1'b1);
      repeat (40) @(negedge clk);
      checks++;
      if (a_if.busy !== 1'b0 || a_if.data_valid !== 1'b0 || obs_a.size() != 0) begin
         failures++;
         $display("FAIL glitch_reject got=b%b/v%b/n%0d exp=b0/v0/n0", a_if.busy, a_if.data_valid,
                  obs_a.size());
      end
   endtask

   task automatic test_overrun();
      logic [7:0] pat [2];
      rec_t o, e;
      bit   got;
      pat = '{8'h11, 8'h22};
      a_if.data_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         exp_a.push_back(rec_t'{16'h0011, 1'b0, 1'b0});
         send_frame(0, 16'(pat[i]), 8, 1'b0, 1'b0, 1'b0, 1'b1);
         wait_obs(0, got);
         checks++;
         if (!got) begin
            failures++;
            exp_a.delete();
            $display("FAIL overrun_pulse got=none exp=%h", pat[i]);
         end else begin
            o = obs_a.pop_front();
            e = exp_a.pop_front();
            checks++;
            if (o !== e) begin
               failures++;
               $display("FAIL overrun_char got=%h/p%b/f%b exp=%h/p%b/f%b", o.data, o.perr, o.ferr,
                        e.data, e.perr, e.ferr);
            end
         end
         checks++;
         if (a_if.overrun !== (i == 1) || a_if.data_valid !== 1'b1) begin
            failures++;
            $display("FAIL overrun_flag got=o%b/v%b exp=o%b/v1", a_if.overrun, a_if.data_valid,
                     (i == 1));
         end
      end
      a_if.overrun_clr = 1'b1;
      @(negedge clk);
      a_if.overrun_clr = 1'b0;
      checks++;
      if (a_if.overrun !== 1'b0) begin
         failures++;
         $display("FAIL overrun_clear got=o%b exp=o0", a_if.overrun);
      end
      a_if.data_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (a_if.data_valid !== 1'b0 || a_if.data_out !== 8'h11) begin
         failures++;
         $display("FAIL overrun_accept got=v%b/%h exp=v0/11", a_if.data_valid, a_if.data_out);
      end
   endtask

   task automatic test_wide_reset();
      logic [11:0] d;
      rec_t o, e;
      bit   got;
      d = 12'hABC;
      w_if.data_ready = 1'b0;
      exp_w.push_back(rec_t'{16'h0ABC, 1'b0, 1'b0});
      send_frame(2, 16'(d), 12, 1'b1, 1'b0, 1'b0, 1'b1);
      wait_obs(2, got);
      checks++;
      if (!got) begin
         failures++;
         exp_w.delete();
         $display("FAIL wide_pulse got=none exp=abc");
      end else begin
         o = obs_w.pop_front();
         e = exp_w.pop_front();
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL wide_char got=%h/p%b/f%b exp=%h/p%b/f%b", o.data, o.perr, o.ferr,
                     e.data, e.perr, e.ferr);
         end
      end
      set_line(2, 1'b0);
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         set_line(2, d[11-i]);
         repeat (BIT) @(negedge clk);
      end
      checks++;
      if (w_if.busy !== 1'b1 || w_if.data_valid !== 1'b1) begin
         failures++;
         $display("FAIL wide_midframe got=b%b/v%b exp=b1/v1", w_if.busy, w_if.data_valid);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({w_if.data_out, w_if.data_valid, w_if.character_received, w_if.parity_err,
           w_if.framing_err, w_if.overrun, w_if.busy} !== '0) begin
         failures++;
         $display("FAIL wide_async_reset got=%h/v%b/b%b exp=0/v0/b0", w_if.data_out,
                  w_if.data_valid, w_if.busy);
      end
      set_line(2, 1'b1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      w_if.data_ready = 1'b1;
      repeat (BIT) @(negedge clk);
      d = 12'h123;
      exp_w.push_back(rec_t'{16'h0123, 1'b0, 1'b0});
      send_frame(2, 16'(d), 12, 1'b1, 1'b0, 1'b0, 1'b1);
      wait_obs(2, got);
      checks++;
      if (!got) begin
         failures++;
         exp_w.delete();
         $display("FAIL wide_after_reset_pulse got=none exp=123");
      end else begin
         o = obs_w.pop_front();
         e = exp_w.pop_front();
         checks++;
         if (o !== e || obs_w.size() != 0) begin
            failures++;
            $display("FAIL wide_after_reset got=%h/p%b/f%b/n%0d exp=%h/p%b/f%b/n0", o.data, o.perr,
                     o.ferr, obs_w.size(), e.data, e.perr, e.ferr);
         end
      end
   endtask

   initial begin
      a_if.data_in = 1'b1;  a_if.data_ready = 1'b1;  a_if.overrun_clr = 1'b0;
      p_if.data_in = 1'b1;  p_if.data_ready = 1'b1;  p_if.overrun_clr = 1'b0;
      w_if.data_in = 1'b1;  w_if.data_ready = 1'b1;  w_if.overrun_clr = 1'b0;
      test_reset();
      test_basic();
      test_parity();
      test_framing();
      test_glitch();
      test_overrun();
      test_wide_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/serial_rx_framed.md
Name: serial_rx_framed

Overview:
- Parametrised single-clock asynchronous serial receiver; successor to the fixed 8-bit, two-divided-clock receiver in the lab 4 link.
- Derives its own oversampling tick from clk; no externally divided clocks.
- Adds configurable width, optional parity, framing/parity error detection, start-bit glitch rejection and a valid/ready output holding register with overrun flag.
- Sits between the GPIO serial line and the microprocessor PIO (data bus, character_received).

Parameters:
- DATA_BITS, 8, payload bits per frame (1..16).
- CLK_DIV, 434, clk cycles per sample tick (>=1); tick = one oversample.
- OVERSAMPLE, 8, sample ticks per bit period (even, >=4).
- PARITY_EN, 0, 1 = one parity bit follows data.
- PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored if PARITY_EN=0.
- MSB_FIRST, 0, 1 = data bit DATA_BITS-1 transmitted first, else LSB first.

Ports:
- clk  in  1  system clock (CLOCK_50).
- rst  in  1  asynchronous, active-low reset.
- data_in  in  1  serial line; idle high; asynchronous to clk.
- data_out  out  DATA_BITS  last accepted character.
- data_valid  out  1  data_out holds an unconsumed character.
- data_ready  in  1  consumer accepts when data_valid & data_ready on a clk edge.
- character_received  out  1  one-clk pulse when a frame completes (good or bad).
- parity_err  out  1  parity status of character in data_out.
- framing_err  out  1  stop bit sampled low for character in data_out.
- overrun  out  1  sticky; a frame completed while data_valid=1 and not consumed.
- overrun_clr  in  1  clears overrun (has priority over set in same cycle).
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=0, async): all outputs 0, state IDLE, tick counter 0, synchroniser flops preset to 1.
- data_in passes a 2-flop synchroniser (preset high); all decisions use synchronised value rx_s.
- Tick generator: counter 0..CLK_DIV-1, tick pulse one clk when counter = CLK_DIV-1; free-running; resets to 0 on entering START.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: rx_s=0 on any clk -> START, sample counter 0.
- START: at tick OVERSAMPLE/2 sample rx_s; 0 -> DATA (bit index 0, sample counter 0); 1 -> IDLE (glitch, no pulse, no flags).
- DATA: sample rx_s every OVERSAMPLE ticks (bit centre); shift into register by MSB_FIRST; after DATA_BITS samples -> PARITY if PARITY_EN else STOP.
- PARITY: one sample; parity_bad = (XOR(data) ^ sample) != PARITY_ODD.
- STOP: one sample; then frame complete -> IDLE same cycle. Next start detectable the clk after.
- Frame complete: character_received=1 for exactly one clk.
  - If data_valid=0 or (data_valid & data_ready same cycle): load data_out, parity_err, framing_err (stop sample=0); data_valid=1.
  - Else: new frame dropped, data_out/flags unchanged, overrun=1.
- Consume: data_valid & data_ready -> data_valid=0 next clk; data_out holds value.
- Bad frames (parity/framing) still delivered; errors are per-character.
- Line held low (break): framing_err frame, then IDLE waits for rx_s high before arming? No: IDLE re-enters START immediately; each break yields repeated framing_err frames with data 0.
- rst mid-frame: immediate abort, outputs cleared; partial frame discarded.
- Latency: character_received rises 2 clk (synchroniser) + stop-bit centre sample + 1 clk after the line stop bit centre.

Test Plan:
- CLK_DIV=4, OVERSAMPLE=8, 8N1 LSB-first, send 0xA5 then 0x3C, data_ready=1 -> two pulses, data_out 0xA5 then 0x3C, no errors.
- PARITY_EN=1 even, send 0x07 with parity 1 -> parity_err=0; parity 0 -> parity_err=1, data_out=0x07.
- Stop bit driven low on 0x55 -> framing_err=1, data_out=0x55, data_valid=1.
- 2-bit-period... start pulse low for 2 ticks only -> no pulse, busy returns 0, data_valid stays 0.
- data_ready=0, send 0x11 then 0x22 -> data_out=0x11, overrun=1; overrun_clr -> 0; ready accepts 0x11.
- DATA_BITS=12, MSB_FIRST=1, send 0xABC; assert rst mid-frame -> all outputs 0; next frame 0x123 received correctly.
